// File: rtl/pulse_mon_pkg.sv
// Shared types and helpers for the pulse rate monitor.
package pulse_mon_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mon_state_e;

  // Window counter width; windows shorter than two cycles are not meaningful.
  function automatic int calc_win_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/window_timer.sv
// Free-running window counter; flags the last cycle of each window while run is high.
module window_timer #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int WIN_W         = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick_last
);

  localparam logic [WIN_W-1:0] LAST = WIN_W'(WINDOW_CYCLES - 1);

  logic [WIN_W-1:0] win_cnt;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      win_cnt <= '0;
    end else if (win_cnt == LAST) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + WIN_W'(1);
    end
  end

  assign tick_last = run && (win_cnt == LAST);

endmodule

// File: rtl/pulse_rate_monitor.sv
// Counts detector pulses per fixed window and publishes one count/alarm report per
// window over valid/ready. States: IDLE | windows stopped, counters held at 0
//                                  RUN  | windows running back-to-back
module pulse_rate_monitor
  import pulse_mon_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int CNT_W         = 8,
  parameter int THRESH        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pulse_in,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_alarm,
  output logic             overrun
);

  localparam int               WIN_W    = calc_win_w(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  mon_state_e       state_q, state_d;
  logic             running;
  logic             tick_last;
  logic             window_end;
  logic [CNT_W-1:0] evt_cnt;
  logic [CNT_W-1:0] evt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping enable leaves RUN immediately; that cycle already counts as stopped.
  always_comb begin
    state_d = state_q;
    running = 1'b0;
    case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          running = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES),
    .WIN_W        (WIN_W)
  ) u_window_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (running),
    .tick_last(tick_last)
  );

  assign window_end = running && tick_last;
  assign evt_next   = (pulse_in && (evt_cnt != CNT_MAX)) ? evt_cnt + CNT_W'(1) : evt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_cnt   <= '0;
      rpt_valid <= 1'b0;
      rpt_count <= '0;
      rpt_alarm <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (!running || window_end) begin
        evt_cnt <= '0;
      end else begin
        evt_cnt <= evt_next;
      end

      // A pulse on the terminal cycle still belongs to the ending window.
      if (window_end && (!rpt_valid || rpt_ready)) begin
        rpt_count <= evt_next;
        rpt_alarm <= (evt_next >= THRESH_C);
        rpt_valid <= 1'b1;
      end else begin
        if (window_end) overrun <= 1'b1;
        if (rpt_valid && rpt_ready) rpt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_rate_monitor.sv
// Directed bench: a 10-cycle-window monitor plus a 2-bit saturating twin on shared stimulus.
module tb_pulse_rate_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       pulse_in = 1'b0;
  logic       rpt_ready = 1'b0;
  logic       rpt_valid, rpt_alarm, overrun;
  logic [7:0] rpt_count;
  logic       rpt_valid_s, rpt_alarm_s, overrun_s;
  logic [1:0] rpt_count_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_rate_monitor #(.WINDOW_CYCLES(10), .CNT_W(8), .THRESH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pulse_in(pulse_in),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_count(rpt_count),
    .rpt_alarm(rpt_alarm), .overrun(overrun)
  );

  pulse_rate_monitor #(.WINDOW_CYCLES(10), .CNT_W(2), .THRESH(3)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .pulse_in(pulse_in),
    .rpt_valid(rpt_valid_s), .rpt_ready(rpt_ready), .rpt_count(rpt_count_s),
    .rpt_alarm(rpt_alarm_s), .overrun(overrun_s)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Spends the current cycle with the given pulse value.
  task automatic run_cycle(input logic p);
    pulse_in = p;
    cyc(1);
    pulse_in = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    cyc(2);
    check("rst_valid",   32'(rpt_valid), 0);
    check("rst_count",   32'(rpt_count), 0);
    check("rst_alarm",   32'(rpt_alarm), 0);
    check("rst_overrun", 32'(overrun),   0);
    rst = 1'b0;

    // 1: pulses at window cycles 1,3,5,7
    enable = 1'b1;
    cyc(1);
    for (int c = 0; c < 10; c++) begin
      run_cycle(c == 1 || c == 3 || c == 5 || c == 7);
      if (c == 8) check("t1_no_early_valid", 32'(rpt_valid), 0);
    end
    check("t1_valid",   32'(rpt_valid), 1);
    check("t1_count",   32'(rpt_count), 4);
    check("t1_alarm",   32'(rpt_alarm), 1);
    check("t1_overrun", 32'(overrun),   0);
    check("t1_sat_count", 32'(rpt_count_s), 3);

    // 2: drain, then pulse only on terminal cycle
    rpt_ready = 1'b1;
    run_cycle(1'b0);
    rpt_ready = 1'b0;
    check("t2_drained", 32'(rpt_valid), 0);
    for (int c = 1; c < 10; c++) run_cycle(c == 9);
    check("t2_valid", 32'(rpt_valid), 1);
    check("t2_count", 32'(rpt_count), 1);
    check("t2_alarm", 32'(rpt_alarm), 0);
    rpt_ready = 1'b1;
    run_cycle(1'b0);
    rpt_ready = 1'b0;
    for (int c = 1; c < 10; c++) run_cycle(1'b0);
    check("t2_next_window_count", 32'(rpt_count), 0);
    check("t2_next_window_valid", 32'(rpt_valid), 1);

    // 3: pulse every cycle
    rpt_ready = 1'b1;
    run_cycle(1'b1);
    rpt_ready = 1'b0;
    for (int c = 1; c < 10; c++) run_cycle(1'b1);
    check("t3_count",     32'(rpt_count),   10);
    check("t3_alarm",     32'(rpt_alarm),   1);
    check("t3_sat_count", 32'(rpt_count_s), 3);
    check("t3_sat_alarm", 32'(rpt_alarm_s), 1);

    // 4: consumer stalls across two window ends
    for (int c = 0; c < 10; c++) run_cycle(c == 2 || c == 4);
    check("t4_held_count", 32'(rpt_count), 10);
    check("t4_held_alarm", 32'(rpt_alarm), 1);
    check("t4_overrun",    32'(overrun),   1);
    for (int c = 0; c < 10; c++) begin
      rpt_ready = (c == 9);
      run_cycle(c < 3);
      if (c == 5) check("t4_stable_count", 32'(rpt_count), 10);
    end
    rpt_ready = 1'b0;
    check("t4_reload_valid",   32'(rpt_valid), 1);
    check("t4_reload_count",   32'(rpt_count), 3);
    check("t4_reload_alarm",   32'(rpt_alarm), 0);
    check("t4_overrun_sticky", 32'(overrun),   1);

    // 5: enable dropped mid-window
    rpt_ready = 1'b1;
    run_cycle(1'b0);
    rpt_ready = 1'b0;
    check("t5_drained", 32'(rpt_valid), 0);
    run_cycle(1'b1);
    run_cycle(1'b0);
    run_cycle(1'b1);
    run_cycle(1'b0);
    enable = 1'b0;
    run_cycle(1'b0);
    cyc(12);
    check("t5_no_partial_report", 32'(rpt_valid), 0);
    enable = 1'b1;
    cyc(1);
    for (int c = 0; c < 10; c++) begin
      run_cycle(c == 0 || c == 9);
      if (c == 8) check("t5_full_window", 32'(rpt_valid), 0);
    end
    check("t5_valid",   32'(rpt_valid), 1);
    check("t5_count",   32'(rpt_count), 2);
    check("t5_overrun", 32'(overrun),   1);

    // 6: reset mid-window with report pending and overrun set
    run_cycle(1'b1);
    run_cycle(1'b0);
    rst = 1'b1;
    cyc(1);
    check("t6_valid",       32'(rpt_valid),   0);
    check("t6_count",       32'(rpt_count),   0);
    check("t6_alarm",       32'(rpt_alarm),   0);
    check("t6_overrun",     32'(overrun),     0);
    check("t6_sat_overrun", 32'(overrun_s),   0);
    check("t6_sat_count",   32'(rpt_count_s), 0);
    rst = 1'b0;
    enable = 1'b0;
    cyc(3);
    check("t6_idle_valid", 32'(rpt_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
